// File: rtl/hilo_mul_sequencer_pkg.sv
// Shared multiply-unit encodings (also used by the instruction decoder) and sequencer states.
package mul_pkg;
  localparam logic [2:0] OP_MADD  = 3'b000;
  localparam logic [2:0] OP_MADDU = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MFLO  = 3'b100;
  localparam logic [2:0] OP_MFHI  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, ACC} state_t;
endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add unsigned multiplier: start loads operands, each step consumes one multiplier bit.
// done pulses during the step that consumes the last bit; product is final after that edge.
module mul_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign done = step && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (start) begin
      mcand   <= {{WIDTH{1'b0}}, mcand_in};
      mplier  <= mplier_in;
      product <= '0;
      cnt     <= '0;
    end else if (step) begin
      if (mplier[0])
        product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hilo_mul_sequencer.sv
// HI/LO multiply sequencer: owns HI/LO, runs MUL/MADD/MADDU over WIDTH+1 cycles, serves MFHI/MFLO.
// stall = issue && busy, so any multiply-unit instruction waits until the unit is idle.
module hilo_mul_sequencer
  import mul_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [2:0] MUL_MADD  = OP_MADD,
  parameter logic [2:0] MUL_MADDU = OP_MADDU,
  parameter logic [2:0] MUL_MUL   = OP_MUL,
  parameter logic [2:0] MUL_MFHI  = OP_MFHI,
  parameter logic [2:0] MUL_MFLO  = OP_MFLO
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic [2:0]       mul_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t             state, next_state;
  logic [2:0]         op_q;
  logic               neg_q;
  logic               start, step, acc_wr, done;
  logic               is_mul, signed_op;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] product, prod_fix;

  assign is_mul    = (mul_op == MUL_MUL) || (mul_op == MUL_MADD) || (mul_op == MUL_MADDU);
  assign signed_op = (mul_op != MUL_MADDU);
  // Negating the most-negative value wraps to itself, which is the correct unsigned magnitude.
  assign rs_mag    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign start     = (state == IDLE) && issue && !flush && is_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (flush)     next_state = IDLE;
        else if (done) next_state = ACC;
      end
      ACC:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    step   = (state == RUN) && !flush;
    acc_wr = (state == ACC) && !flush;
  end

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step      (step),
    .mcand_in  (rs_mag),
    .mplier_in (rt_mag),
    .product   (product),
    .done      (done)
  );

  assign prod_fix = neg_q ? -product : product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
    end else begin
      if (start) begin
        op_q  <= mul_op;
        neg_q <= signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      end
      if (acc_wr) begin
        if (op_q == MUL_MUL) {hi, lo} <= prod_fix;
        else                 {hi, lo} <= {hi, lo} + prod_fix;
      end
    end
  end

  assign stall  = issue && busy;
  assign result = (mul_op == MUL_MFHI) ? hi : lo;
endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Directed bench for hilo_mul_sequencer with hand-computed expectations (WIDTH=32).
module tb_hilo_mul_sequencer;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue = 1'b0;
  logic [2:0]  mul_op = OP_MFLO;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        stall, busy;
  logic [31:0] result, hi, lo;

  int vectors = 0;
  int miscompares = 0;
  int n;

  hilo_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .mul_op(mul_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .stall(stall), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue = 1'b1; mul_op = op; rs_val = a; rt_val = b;
    cyc();
    issue = 1'b0; mul_op = OP_MFLO;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    settle();
    while (busy && cnt < 60) begin
      cnt++;
      cyc();
      settle();
    end
  endtask

  initial begin
    #12;
    settle();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    cyc();

    // MUL 7 x -3 = -21
    launch(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    count_busy(n);
    chk("mul7x-3_busy_cycles", n, 32'd33);
    chk("mul7x-3_hi", hi, 32'hFFFF_FFFF);
    chk("mul7x-3_lo", lo, 32'hFFFF_FFEB);
    chk("mul7x-3_result_lo", result, 32'hFFFF_FFEB);

    // Most-negative squared = 2^62
    launch(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    count_busy(n);
    chk("mulmin_hi", hi, 32'h4000_0000);
    chk("mulmin_lo", lo, 32'h0);

    // 0xFFFF x 0x10001 = 0xFFFFFFFF, then MADDU 1x1 carries into HI
    launch(OP_MUL, 32'h0000_FFFF, 32'h0001_0001);
    count_busy(n);
    chk("mulffff_hi", hi, 32'h0);
    chk("mulffff_lo", lo, 32'hFFFF_FFFF);
    launch(OP_MADDU, 32'd1, 32'd1);
    count_busy(n);
    chk("maddu_carry_hi", hi, 32'h1);
    chk("maddu_carry_lo", lo, 32'h0);

    // MUL 5x6 then MFLO held for the whole operation
    launch(OP_MUL, 32'd5, 32'd6);
    issue = 1'b1; mul_op = OP_MFLO;
    n = 0;
    settle();
    while (stall && n < 60) begin
      n++;
      cyc();
      settle();
    end
    chk("mflo_stall_cycles", n, 32'd33);
    chk("mflo_result", result, 32'd30);
    mul_op = OP_MFHI;
    settle();
    chk("mfhi_result", result, 32'd0);
    issue = 1'b0; mul_op = OP_MFLO;

    // 5769 x 6700417 = 9 * (2^32 + 1) -> HI = LO = 9
    launch(OP_MUL, 32'd5769, 32'd6700417);
    count_busy(n);
    chk("set9_hi", hi, 32'd9);
    chk("set9_lo", lo, 32'd9);

    // Flush in RUN cycle 10
    launch(OP_MUL, 32'd2, 32'd2);
    repeat (9) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    settle();
    chk("flush_run_busy", {31'b0, busy}, 32'd0);
    repeat (40) cyc();
    settle();
    chk("flush_run_hi", hi, 32'd9);
    chk("flush_run_lo", lo, 32'd9);

    // Flush during ACC wins over the write
    launch(OP_MUL, 32'd2, 32'd2);
    repeat (32) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    settle();
    chk("flush_acc_busy", {31'b0, busy}, 32'd0);
    chk("flush_acc_hi", hi, 32'd9);
    chk("flush_acc_lo", lo, 32'd9);

    // Flush together with issue in IDLE: issue ignored
    flush = 1'b1;
    launch(OP_MUL, 32'd2, 32'd2);
    flush = 1'b0;
    settle();
    chk("flush_issue_busy", {31'b0, busy}, 32'd0);
    chk("flush_issue_lo", lo, 32'd9);

    // Unknown op code is ignored
    launch(3'b111, 32'd2, 32'd2);
    settle();
    chk("unknown_op_busy", {31'b0, busy}, 32'd0);

    // Reset during MADD RUN
    launch(OP_MADD, 32'd3, 32'd4);
    repeat (5) cyc();
    issue = 1'b1; mul_op = OP_MFHI;
    rst_n = 1'b0;
    settle();
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_stall", {31'b0, stall}, 32'd0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    settle();
    chk("midrst_mfhi", result, 32'h0);
    issue = 1'b0; mul_op = OP_MFLO;
    repeat (40) cyc();
    settle();
    chk("midrst_no_write_lo", lo, 32'h0);

    // Back-to-back signed MADDs: -2*3 = -6, then held -1*-1 adds 1
    launch(OP_MADD, 32'hFFFF_FFFE, 32'd3);
    issue = 1'b1; mul_op = OP_MADD; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    n = 0;
    settle();
    while (stall && n < 60) begin
      n++;
      cyc();
      settle();
    end
    chk("b2b_stall_cycles", n, 32'd33);
    chk("b2b_first_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_first_lo", lo, 32'hFFFF_FFFA);
    cyc();
    issue = 1'b0; mul_op = OP_MFLO;
    count_busy(n);
    chk("b2b_second_busy_cycles", n, 32'd33);
    chk("b2b_hi", hi, 32'hFFFF_FFFF);
    chk("b2b_lo", lo, 32'hFFFF_FFFB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
